noc_input_port: RTL and testbench
=================================

# noc_input_port

Router input port that sits directly downstream of a processing element's TX buffer. It accepts 20-bit flits from the PE (or a neighbouring router), holds them in a DEPTH-entry FIFO, and computes an XY route request for the head flit. It returns one credit pulse per dequeued flit so the upstream credit counter can track free slots.

## Interface
- DEPTH, 8, FIFO entries (power of two, 2..16); the upstream credit limit must be ≤ DEPTH.
- MY_X, 0, this router's X coordinate (2 bits).
- MY_Y, 0, this router's Y coordinate (2 bits).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flit_in  input  20  incoming flit: [19:18] dest X, [17:16] dest Y, [15:0] payload.
- in_valid  input  1  flit_in valid this cycle.
- credit_out  output  1  one-cycle credit pulse to upstream (drives the PE `ci`).
- flit_out  output  20  head-of-FIFO flit.
- out_valid  output  1  FIFO non-empty; flit_out and route_req are meaningful.
- route_req  output  5  one-hot output-port request: bit0 Local, bit1 N, bit2 E, bit3 S, bit4 W.
- grant  input  1  switch allocator accepts the head flit; pops it.
- count  output  log2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when a flit arrives while the FIFO is full and no pop occurs.

## Operation
- FIFO: write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- Push: in_valid=1 and (count<DEPTH or pop this cycle) → flit_in written at wr_ptr, wr_ptr++.
- Pop: grant=1 and out_valid=1 → rd_ptr++. Grant while empty is ignored: no pop, no credit.
- Simultaneous push and pop: both happen and count is unchanged. This also holds when full and when count=1.
- Push while full without pop: flit dropped, pointers unchanged, overflow←1, held until reset.
- credit_out: registered; equals 1 in the cycle after each pop, else 0. Back-to-back pops give back-to-back pulses.
- Route (combinational from head flit, XY order):
  - dest X > MY_X → E.
  - dest X < MY_X → W.
  - Otherwise, dest Y > MY_Y → N.
  - Otherwise, dest Y < MY_Y → S.
  - Otherwise → Local.
  - route_req = 0 when empty. Exactly one bit is set when non-empty.
- flit_out = storage[rd_ptr]. Its value is don't-care when empty. The bench checks it only with out_valid=1.

## Timing
- Reset values: pointers, count, overflow, credit_out all 0. out_valid=0, route_req=0. flit_out is don't-care.
- Reset mid-operation: all contents discarded immediately (asynchronous). No credit is issued for discarded flits; upstream is reset by the same rst.
- Write latency: a flit pushed at edge N has out_valid=1 and a valid route_req after edge N. It is grantable in cycle N+1.
- Pop-to-credit: grant sampled at edge N → credit_out high between edges N and N+1.
- Max throughput: one push and one pop per cycle.

## Configuration
- NOC_INPORT_STATS_EN defined:
  - Adds output flit_cnt [15:0], counting accepted pushes.
  - Increments once per accepted push; dropped flits are not counted.
  - Wraps 0xFFFF→0.
  - Reset to 0.
- NOC_INPORT_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then single flit 0x5_1234 (dest X=1, Y=1) with MY_X=MY_Y=1:
  - After the edge: out_valid=1, route_req=00001, count=1.
  - Grant: count=0, and credit_out=1 for exactly one cycle in the following cycle.
- Route check with MY_X=1, MY_Y=1:
  - dest(3,1) → 00100 (E); dest(0,2) → 10000 (W); dest(1,3) → 00010 (N); dest(1,0) → 01000 (S).
- Fill 8 flits with no grant → count=8. A 9th in_valid drops the flit, overflow=1, count stays 8. Then grant 8 times → flits 1–8 emerge in order and 8 credit pulses are issued.
- When full, drive in_valid and grant together → count stays 8, overflow stays 0, the new flit emerges last.
- Grant while empty → no credit pulse, count stays 0.
- Assert rst low mid-stream with count=5 → count=0, out_valid=0, credit_out=0 immediately. With NOC_INPORT_STATS_EN defined, flit_cnt=0.

Source files
------------

// File: rtl/noc_input_port.sv
// Router input port: DEPTH-entry flit FIFO with XY route request for the head flit and credit return.
// Optional flit counter output flit_cnt is enabled with NOC_INPORT_STATS_EN.

package noc_input_port_pkg;
    localparam int unsigned FLIT_W    = 20;
    localparam int unsigned COORD_W   = 2;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned PORT_N    = 5;
    localparam int unsigned STATS_W   = 16;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_N_DIR = 1;
    localparam int unsigned PORT_E = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_W = 4;

    typedef struct packed {
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;
endpackage

module noc_input_port
    import noc_input_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned MY_X  = 0,
    parameter int unsigned MY_Y  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [19:0]             flit_in,
    input  logic                    in_valid,
    output logic                    credit_out,
    output logic [19:0]             flit_out,
    output logic                    out_valid,
    output logic [4:0]              route_req,
    input  logic                    grant,
    output logic [$clog2(DEPTH):0]  count,
`ifdef NOC_INPORT_STATS_EN
    output logic [15:0]             flit_cnt,
`endif
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [COORD_W-1:0] MY_XL = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_YL = COORD_W'(MY_Y);

    flit_t          mem [DEPTH];
    flit_t          head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           drop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a flit when granted.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        pop   = grant && !empty;
        push  = in_valid && (!full || pop);
        drop  = in_valid && full && !pop;
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            credit_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            out_valid  <= (count_next != '0);
            credit_out <= pop;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; contents are only observed through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_t'(flit_in);
        end
    end

    always_comb begin
        head     = mem[rd_ptr];
        flit_out = head;
    end

    // XY dimension-ordered route: resolve X first, then Y, else eject locally.
    always_comb begin
        route_req = '0;
        if (out_valid) begin
            if (head.dest_x > MY_XL) begin
                route_req[PORT_E] = 1'b1;
            end else if (head.dest_x < MY_XL) begin
                route_req[PORT_W] = 1'b1;
            end else if (head.dest_y > MY_YL) begin
                route_req[PORT_N_DIR] = 1'b1;
            end else if (head.dest_y < MY_YL) begin
                route_req[PORT_S] = 1'b1;
            end else begin
                route_req[PORT_L] = 1'b1;
            end
        end
    end

`ifdef NOC_INPORT_STATS_EN
    // Accepted-push counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt <= '0;
        end else if (push) begin
            flit_cnt <= flit_cnt + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Randomized and directed bench for noc_input_port against a queue-based reference model.
// Build with NOC_INPORT_STATS_EN defined to also check flit_cnt.

module tb_noc_input_port;

    localparam int DEPTH = 8;
    localparam int MY_X  = 1;
    localparam int MY_Y  = 1;

    logic        clk;
    logic        rst;
    logic [19:0] flit_in;
    logic        in_valid;
    logic        credit_out;
    logic [19:0] flit_out;
    logic        out_valid;
    logic [4:0]  route_req;
    logic        grant;
    logic [3:0]  count;
    logic        overflow;
`ifdef NOC_INPORT_STATS_EN
    logic [15:0] flit_cnt;
`endif

    noc_input_port #(.DEPTH(DEPTH), .MY_X(MY_X), .MY_Y(MY_Y)) dut (
        .clk        (clk),
        .rst        (rst),
        .flit_in    (flit_in),
        .in_valid   (in_valid),
        .credit_out (credit_out),
        .flit_out   (flit_out),
        .out_valid  (out_valid),
        .route_req  (route_req),
        .grant      (grant),
        .count      (count),
`ifdef NOC_INPORT_STATS_EN
        .flit_cnt   (flit_cnt),
`endif
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [19:0] q[$];
    bit          ovf_m;
    bit          cred_m;
    int          cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_route(input logic [19:0] f);
        int dx = int'(f[19:18]);
        int dy = int'(f[17:16]);
        int idx;
        if (dx > MY_X)      idx = 2;
        else if (dx < MY_X) idx = 4;
        else if (dy > MY_Y) idx = 1;
        else if (dy < MY_Y) idx = 3;
        else                idx = 0;
        return 5'(1 << idx);
    endfunction

    task automatic check_all();
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("route_req", 32'(route_req), (q.size() != 0) ? 32'(exp_route(q[0])) : 32'd0);
        if (q.size() != 0) check("flit_out", 32'(flit_out), 32'(q[0]));
        check("credit_out", 32'(credit_out), 32'(cred_m));
        check("overflow", 32'(overflow), 32'(ovf_m));
`ifdef NOC_INPORT_STATS_EN
        check("flit_cnt", 32'(flit_cnt), 32'(cnt_m & 16'hFFFF));
`endif
    endtask

    task automatic step(input logic iv, input logic [19:0] f, input logic gr);
        bit pop_m, push_m;
        @(negedge clk);
        in_valid = iv;
        flit_in  = f;
        grant    = gr;
        pop_m  = gr && (q.size() > 0);
        push_m = iv && ((q.size() < DEPTH) || pop_m);
        @(posedge clk);
        #1;
        if (pop_m)  void'(q.pop_front());
        if (push_m) begin
            q.push_back(f);
            cnt_m++;
        end
        if (iv && !push_m) ovf_m = 1'b1;
        cred_m = pop_m;
        check_all();
    endtask

    // Asserts reset between edges and checks that state clears without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        q.delete();
        ovf_m  = 1'b0;
        cred_m = 1'b0;
        cnt_m  = 0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_credit", 32'(credit_out), 32'd0);
        check("rst_route", 32'(route_req), 32'd0);
`ifdef NOC_INPORT_STATS_EN
        check("rst_flit_cnt", 32'(flit_cnt), 32'd0);
`endif
        in_valid = 1'b0;
        grant    = 1'b0;
        flit_in  = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [19:0] mk(input int x, input int y, input int p);
        return {2'(x), 2'(y), 16'(p)};
    endfunction

    initial begin
        logic [19:0] extra;
        n_vec = 0; n_err = 0;
        ovf_m = 0; cred_m = 0; cnt_m = 0;
        rst = 1'b1; in_valid = 1'b0; grant = 1'b0; flit_in = '0;
        #2;
        do_reset();
        check_all();

        // Single local flit, then grant and credit.
        step(1'b1, 20'h51234, 1'b0);
        check("t1_route_local", 32'(route_req), 32'h01);
        step(1'b0, '0, 1'b1);
        check("t1_credit", 32'(credit_out), 32'd1);
        step(1'b0, '0, 1'b0);
        check("t1_credit_once", 32'(credit_out), 32'd0);

        // Four directions.
        step(1'b1, mk(3, 1, 16'hA001), 1'b0);
        check("route_e", 32'(route_req), 32'h04);
        step(1'b1, mk(0, 2, 16'hA002), 1'b1);
        check("route_w", 32'(route_req), 32'h10);
        step(1'b1, mk(1, 3, 16'hA003), 1'b1);
        check("route_n", 32'(route_req), 32'h02);
        step(1'b1, mk(1, 0, 16'hA004), 1'b1);
        check("route_s", 32'(route_req), 32'h08);
        step(1'b0, '0, 1'b1);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, mk(i % 4, i / 4, 16'hB000 + i), 1'b0);
        check("full_count", 32'(count), 32'd8);
        step(1'b1, 20'hFFFFF, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together while full.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, mk(i % 4, 3 - (i % 4), 16'hC000 + i), 1'b0);
        extra = mk(2, 2, 16'hCEEE);
        step(1'b1, extra, 1'b1);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
        check("fullpp_last", 32'(flit_out), 32'(extra));
        step(1'b0, '0, 1'b1);

        // Grant while empty.
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("empty_grant_cnt", 32'(count), 32'd0);
        step(1'b0, '0, 1'b0);
        check("empty_grant_cred", 32'(credit_out), 32'd0);

        // Reset mid-stream with count=5 and a credit pending.
        for (int i = 0; i < 6; i++) step(1'b1, mk(i, i + 1, 16'hD000 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        check("mid_count5", 32'(count), 32'd5);
        do_reset();

        // Randomized traffic in phases biased toward filling, draining, or balanced.
        for (int i = 0; i < 2400; i++) begin
            int ph;
            int piv;
            int pgr;
            ph = (i / 150) % 3;
            piv = (ph == 0) ? 85 : (ph == 1) ? 30 : 60;
            pgr = (ph == 0) ? 25 : (ph == 1) ? 85 : 60;
            step(1'b1 && ($urandom_range(0, 99) < piv), 20'($urandom), ($urandom_range(0, 99) < pgr));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
